dts_result_collector: RTL

DTS_RESULT_COLLECTOR -- requirements
Module: dts_result_collector

---
 rtl/dts_result_collector.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dts_result_collector.sv
// dts_result_collector: checks search candidates for distinct differences and queues the accepted ones
module dts_result_collector #(
    parameter int N     = 3,
    parameter int M     = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N*(M+1)-1:0]       res_in,
    input  logic                     done_in,
    output logic [N*(M+1)-1:0]       out_data,
    output logic [$clog2(M+1)-1:0]   out_scope,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [31:0]              sol_count,
    output logic [15:0]              drop_count
);
    localparam int B  = M + 1;
    localparam int W  = N * B;
    localparam int SW = $clog2(B);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CHECK, PUSH} state_t;

    state_t          state, next;
    logic [W-1:0]    cand;
    logic [M:0]      acc, blk, mask;
    logic            err, blk_err;
    logic [IW-1:0]   idx;
    logic [SW-1:0]   scope;
    logic [W+SW-1:0] mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     cnt;
    logic            full, pop, push_ok, wr, lost, ign;
    logic [16:0]     drop_sum;

    assign full     = cnt == (AW+1)'(DEPTH);
    assign pop      = out_valid & out_ready;
    assign push_ok  = reset && state == PUSH && !err;
    assign wr       = push_ok && (!full || pop);
    assign lost     = push_ok && !wr;
    assign ign      = done_in && state != IDLE;
    assign drop_sum = {1'b0, drop_count} + 17'(lost) + 17'(ign);
    assign out_valid = cnt != '0;
    assign {out_data, out_scope} = out_valid ? mem[rptr] : '0;
    assign busy     = state != IDLE;

    // difference mask and error test for the block currently selected by idx
    always_comb begin
        blk  = cand[idx*B +: B];
        mask = '0;
        for (int d = 1; d <= M; d++) mask[d] = |(blk & (blk >> d));
        blk_err = !blk[0] || ($countones(mask) != $countones(blk) * ($countones(blk) - 1) / 2) || |(mask & acc);
    end

    // scope is the highest mark present in any block of the candidate
    always_comb begin
        scope = '0;
        for (int b = 0; b < N; b++)
            for (int i = 0; i < B; i++)
                if (cand[b*B+i] && SW'(i) > scope) scope = SW'(i);
    end

    // next-state selection: IDLE waits for a strobe, CHECK walks the blocks, PUSH lasts one cycle
    always_comb begin
        next = state == IDLE  ? (done_in ? CHECK : IDLE) :
               state == CHECK ? (idx == IW'(N-1) ? PUSH : CHECK) : IDLE;
    end

    // FSM state, candidate latch and per-block accumulation
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cand  <= '0;
            acc   <= '0;
            err   <= 1'b0;
            idx   <= '0;
        end else begin
            state <= next;
            if (state == IDLE && done_in) begin
                cand <= res_in;
                acc  <= '0;
                err  <= 1'b0;
                idx  <= '0;
            end else if (state == CHECK) begin
                err <= err | blk_err;
                acc <= acc | mask;
                idx <= idx + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; a pop in the same cycle makes room for a write when full
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end

    // FIFO storage needs no reset since the occupancy count gates visibility
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= {cand, scope};
    end

    // saturating solution and drop counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            sol_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok && sol_count != '1) sol_count <= sol_count + 1'b1;
            drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
        end
    end
endmodule
